// File: rtl/setting_mode_arbiter.sv
// Operating-mode arbiter: OFF / STANDBY / SET / RUN with a SET-mode inactivity timer.
// Requests are resolved by per-mode priority; the timer counts tick_1s pulses and reloads on key activity.
module setting_mode_arbiter #(
    parameter int MODE_WIDTH = 2,
    parameter int TIMEOUT_S  = 10
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  power_btn,
    input  logic                  set_req,
    input  logic                  run_req,
    input  logic                  stand_from_setting_toggle,
    input  logic                  key_activity,
    input  logic                  tick_1s,
    output logic [MODE_WIDTH-1:0] current_mode,
    output logic                  mode_changed,
    output logic                  set_timeout,
    output logic [7:0]            set_remaining
);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_STANDBY = 2'd1,
        MODE_SET     = 2'd2,
        MODE_RUN     = 2'd3
    } mode_t;

    localparam logic [7:0] TIMEOUT_LD = 8'(TIMEOUT_S);

    mode_t      mode_q;
    mode_t      mode_d;
    logic       power_btn_d;
    logic       power_edge;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       timeout_cond;
    logic       timeout_d;
    logic       mode_changed_q;
    logic       set_timeout_q;

    assign power_edge   = power_btn & ~power_btn_d;
    assign timeout_cond = (cnt_q == 8'd1) & tick_1s & ~key_activity;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode_q         <= MODE_OFF;
            power_btn_d    <= 1'b0;
            cnt_q          <= 8'd0;
            mode_changed_q <= 1'b0;
            set_timeout_q  <= 1'b0;
        end else begin
            mode_q         <= mode_d;
            power_btn_d    <= power_btn;
            cnt_q          <= cnt_d;
            mode_changed_q <= (mode_d != mode_q);
            set_timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        mode_d    = mode_q;
        timeout_d = 1'b0;
        cnt_d     = 8'd0;

        case (mode_q)
            MODE_OFF: begin
                if (power_edge) mode_d = MODE_STANDBY;
            end
            MODE_STANDBY: begin
                if (power_edge)   mode_d = MODE_OFF;
                else if (set_req) mode_d = MODE_SET;
                else if (run_req) mode_d = MODE_RUN;
            end
            MODE_SET: begin
                if (power_edge)                     mode_d = MODE_OFF;
                else if (stand_from_setting_toggle) mode_d = MODE_STANDBY;
                else if (timeout_cond) begin
                    mode_d    = MODE_STANDBY;
                    timeout_d = 1'b1;
                end
            end
            MODE_RUN: begin
                if (power_edge)   mode_d = MODE_OFF;
                else if (run_req) mode_d = MODE_STANDBY;
                else if (set_req) mode_d = MODE_SET;
            end
            default: mode_d = MODE_OFF;
        endcase

        // Counter lives only in SET; any other next mode clears it.
        if (mode_d == MODE_SET) begin
            if ((mode_q != MODE_SET) || key_activity) cnt_d = TIMEOUT_LD;
            else if (tick_1s && (cnt_q != 8'd0))      cnt_d = cnt_q - 8'd1;
            else                                      cnt_d = cnt_q;
        end
    end

    assign current_mode  = MODE_WIDTH'(mode_q);
    assign mode_changed  = mode_changed_q;
    assign set_timeout   = set_timeout_q;
    assign set_remaining = cnt_q;

endmodule

// File: tb/tb_setting_mode_arbiter.sv
// Bench for setting_mode_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_setting_mode_arbiter;

    localparam int TO = 10;

    logic       clk = 1'b0;
    logic       rstn;
    logic       power_btn, set_req, run_req, stand_from_setting_toggle, key_activity, tick_1s;
    logic [1:0] current_mode;
    logic       mode_changed, set_timeout;
    logic [7:0] set_remaining;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state: mode as integer 0..3, seconds left, previous key level.
    int m_mode, m_rem, m_chg, m_to;
    bit m_pbd;

    setting_mode_arbiter #(.MODE_WIDTH(2), .TIMEOUT_S(TO)) dut (
        .clk                       (clk),
        .rstn                      (rstn),
        .power_btn                 (power_btn),
        .set_req                   (set_req),
        .run_req                   (run_req),
        .stand_from_setting_toggle (stand_from_setting_toggle),
        .key_activity              (key_activity),
        .tick_1s                   (tick_1s),
        .current_mode              (current_mode),
        .mode_changed              (mode_changed),
        .set_timeout               (set_timeout),
        .set_remaining             (set_remaining)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_rem = 0; m_chg = 0; m_to = 0; m_pbd = 0;
    endtask

    task automatic model_clock(input bit pb, sr, rr, tg, ka, tk);
        bit pe;
        int nm;
        pe   = pb && !m_pbd;
        nm   = m_mode;
        m_to = 0;
        case (m_mode)
            0: if (pe) nm = 1;
            1: if (pe) nm = 0; else if (sr) nm = 2; else if (rr) nm = 3;
            2: if (pe) nm = 0; else if (tg) nm = 1;
               else if (m_rem == 1 && tk && !ka) begin nm = 1; m_to = 1; end
            default: if (pe) nm = 0; else if (rr) nm = 1; else if (sr) nm = 2;
        endcase
        if (nm != 2)               m_rem = 0;
        else if (m_mode != 2 || ka) m_rem = TO;
        else if (tk && m_rem > 0)  m_rem = m_rem - 1;
        m_chg  = (nm != m_mode);
        m_mode = nm;
        m_pbd  = pb;
    endtask

    task automatic check_model();
        chk("mode",      int'(current_mode),  m_mode);
        chk("remaining", int'(set_remaining), m_rem);
        chk("changed",   int'(mode_changed),  m_chg);
        chk("timeout",   int'(set_timeout),   m_to);
    endtask

    // Drive one cycle of inputs, clock, then compare against the model.
    task automatic step(input bit pb, sr, rr, tg, ka, tk);
        power_btn = pb; set_req = sr; run_req = rr;
        stand_from_setting_toggle = tg; key_activity = ka; tick_1s = tk;
        @(posedge clk);
        model_clock(pb, sr, rr, tg, ka, tk);
        #1;
        check_model();
    endtask

    task automatic idle(); step(0, 0, 0, 0, 0, 0); endtask
    task automatic tick(); step(0, 0, 0, 0, 0, 1); endtask

    initial begin
        bit pb;
        rstn = 1'b0;
        power_btn = 0; set_req = 0; run_req = 0;
        stand_from_setting_toggle = 0; key_activity = 0; tick_1s = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_mode", int'(current_mode), 0);
        chk("rst_rem",  int'(set_remaining), 0);
        chk("rst_chg",  int'(mode_changed), 0);
        chk("rst_to",   int'(set_timeout), 0);
        rstn = 1'b1;
        idle();

        // Power key rising edge, then held high.
        step(1, 0, 0, 0, 0, 0);
        chk("pwr_on_mode", int'(current_mode), 1);
        chk("pwr_on_chg",  int'(mode_changed), 1);
        step(1, 0, 0, 0, 0, 0);
        chk("pwr_hold_mode", int'(current_mode), 1);
        chk("pwr_hold_chg",  int'(mode_changed), 0);
        step(1, 1, 0, 0, 0, 0);
        chk("pwr_hold2_mode", int'(current_mode), 2);
        step(0, 0, 0, 1, 0, 0);
        chk("toggle_exit", int'(current_mode), 1);

        // Full inactivity timeout.
        step(0, 1, 0, 0, 0, 0);
        chk("set_entry_mode", int'(current_mode), 2);
        chk("set_entry_rem",  int'(set_remaining), 10);
        repeat (9) tick();
        chk("rem_after9", int'(set_remaining), 1);
        chk("mode_after9", int'(current_mode), 2);
        tick();
        chk("to_mode", int'(current_mode), 1);
        chk("to_pulse", int'(set_timeout), 1);
        chk("to_chg", int'(mode_changed), 1);
        chk("to_rem", int'(set_remaining), 0);
        idle();
        chk("to_pulse_end", int'(set_timeout), 0);

        // Key activity coinciding with a tick reloads.
        step(0, 1, 0, 0, 0, 0);
        repeat (7) tick();
        chk("rem_after7", int'(set_remaining), 3);
        step(0, 0, 0, 0, 1, 1);
        chk("reload_rem", int'(set_remaining), 10);
        chk("reload_mode", int'(current_mode), 2);
        chk("reload_chg", int'(mode_changed), 0);

        // Toggle beats timeout in the same cycle.
        repeat (9) tick();
        chk("rem_at1", int'(set_remaining), 1);
        step(0, 0, 0, 1, 0, 1);
        chk("tg_mode", int'(current_mode), 1);
        chk("tg_to", int'(set_timeout), 0);
        chk("tg_rem", int'(set_remaining), 0);

        // Priority in STANDBY and RUN.
        step(0, 1, 1, 0, 0, 0);
        chk("sb_prio", int'(current_mode), 2);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("run_entry", int'(current_mode), 3);
        step(1, 0, 1, 0, 0, 0);
        chk("run_pwr_prio", int'(current_mode), 0);
        idle();

        // Reset mid-SET with 4 seconds left.
        step(1, 0, 0, 0, 0, 0);
        idle();
        step(0, 1, 0, 0, 0, 0);
        repeat (6) tick();
        chk("rem_at4", int'(set_remaining), 4);
        #2 rstn = 1'b0;
        #1;
        chk("arst_mode", int'(current_mode), 0);
        chk("arst_rem",  int'(set_remaining), 0);
        chk("arst_to",   int'(set_timeout), 0);
        model_reset();
        tick_1s = 1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            chk("arst_hold_to", int'(set_timeout), 0);
        end
        tick_1s = 0;

        // Power key already high when reset releases.
        power_btn = 1;
        #2 rstn = 1'b1;
        step(1, 0, 0, 0, 0, 0);
        chk("rel_pwr_mode", int'(current_mode), 1);
        chk("rel_pwr_chg", int'(mode_changed), 1);

        // Randomized traffic.
        pb = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) pb = ~pb;
            step(pb,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 2) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/setting_mode_arbiter.md
SETTING_MODE_ARBITER -- requirements
Module: setting_mode_arbiter

Interface
REQ-001 The block SHALL have parameter MODE_WIDTH, default 2, giving the width of the mode code.
REQ-002 The block SHALL have parameter TIMEOUT_S, default 10, legal range 1..255, giving the SET-mode inactivity timeout in seconds.
REQ-003 The block SHALL use fixed mode codes: OFF=0, STANDBY=1, SET=2, RUN=3.
REQ-004 The block SHALL have these ports:
- clk  input  1  system clock; one clock domain.
- rstn  input  1  reset; asynchronous, active-low.
- power_btn  input  1  debounced power key, level.
- set_req  input  1  one-cycle pulse requesting SET mode.
- run_req  input  1  one-cycle pulse requesting RUN (extraction) mode, or its toggle-off.
- stand_from_setting_toggle  input  1  one-cycle pulse from the setting-exit detector.
- key_activity  input  1  one-cycle pulse on any user key press.
- tick_1s  input  1  one-cycle pulse, once per second.
- current_mode  output  MODE_WIDTH  registered current mode.
- mode_changed  output  1  one-cycle pulse on any mode change.
- set_timeout  output  1  one-cycle pulse when SET mode exits on inactivity.
- set_remaining  output  8  seconds left before SET timeout; 0 outside SET.

Function
REQ-005 The block SHALL register power_btn into power_btn_d each cycle and define power_edge = power_btn & ~power_btn_d.
REQ-006 All mode transitions SHALL take effect on the clock edge at which the request is sampled, giving 1-cycle latency from request to current_mode.
REQ-007 OFF mode transitions SHALL be:
- power_edge -> STANDBY.
- All other requests ignored.
REQ-008 STANDBY mode transitions SHALL be, in priority order:
- power_edge -> OFF.
- else set_req -> SET.
- else run_req -> RUN.
REQ-009 SET mode transitions SHALL be, in priority order:
- power_edge -> OFF.
- else stand_from_setting_toggle -> STANDBY.
- else inactivity timeout -> STANDBY.
- set_req and run_req ignored.
REQ-010 RUN mode transitions SHALL be, in priority order:
- power_edge -> OFF.
- else run_req -> STANDBY.
- else set_req -> SET.
REQ-011 Only one transition SHALL occur per cycle; lower-priority simultaneous requests are discarded, not queued.
REQ-012 The inactivity counter SHALL be an 8-bit register loaded with TIMEOUT_S on entry to SET.
REQ-013 While in SET with no transition, key_activity SHALL reload the counter to TIMEOUT_S; else tick_1s SHALL decrement it.
REQ-014 key_activity and tick_1s in the same cycle SHALL reload the counter, with no decrement.
REQ-015 The timeout condition SHALL be counter == 1 & tick_1s & ~key_activity.
REQ-016 On the timeout condition, the block SHALL transition to STANDBY and pulse set_timeout, unless a higher-priority request exits SET in the same cycle.
REQ-017 If a higher-priority request exits SET in the timeout cycle, set_timeout SHALL stay 0.
REQ-018 The counter SHALL never wrap below 0 and SHALL read 0 in every mode other than SET.
REQ-019 set_remaining SHALL equal the counter register.
REQ-020 mode_changed SHALL pulse for exactly the one cycle in which current_mode holds its new value.
REQ-021 mode_changed SHALL be 0 when a request leaves the mode unchanged.
REQ-022 set_timeout SHALL be registered and aligned with the mode_changed pulse of the timeout transition.

Reset
REQ-023 While rstn=0, the block SHALL hold current_mode=OFF, power_btn_d=0, counter=0, mode_changed=0, set_timeout=0.
REQ-024 Reset assertion mid-SET SHALL abort the timer immediately, with no set_timeout pulse.
REQ-025 If power_btn is high at reset release, the first clock SHALL see power_edge=1 and enter STANDBY.

Verification
REQ-026 Bench SHALL cover: power_btn 0->1 from OFF -> next edge current_mode=1, mode_changed=1 for one cycle; holding power_btn high -> no further change.
REQ-027 Bench SHALL cover: STANDBY, set_req -> SET with set_remaining=10; 10 tick_1s pulses with no keys -> STANDBY on the 10th tick, with set_timeout=1 and mode_changed=1 in the same cycle.
REQ-028 Bench SHALL cover: SET, 7 ticks (set_remaining=3), then key_activity together with tick_1s -> set_remaining=10, mode stays SET.
REQ-029 Bench SHALL cover: SET with set_remaining=1, tick_1s and stand_from_setting_toggle in the same cycle -> STANDBY, set_timeout=0, set_remaining=0.
REQ-030 Bench SHALL cover: STANDBY, set_req and run_req together -> SET; RUN, power_edge and run_req together -> OFF.
REQ-031 Bench SHALL cover: rstn pulsed low mid-SET with set_remaining=4 -> immediately current_mode=0 and set_remaining=0; no set_timeout pulse ever appears.
